// File: rtl/alu_multicycle.sv
// Execute-stage ALU: single-cycle logic/arith ops plus iterative multu/divu with HI/LO result.
// Latency: 1 cycle (single/illegal), WIDTH+1 cycles (multu/divu); in_ready low until the result is consumed.
module alu_multicycle #(
    parameter int WIDTH  = 32,
    parameter bit MUL_EN = 1'b1,
    parameter bit DIV_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       control,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic             zero,
    output logic             div_by_zero,
    output logic             illegal_op
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [2:0] {S_IDLE, S_EXEC1, S_MUL, S_DIV, S_DONE} state_t;
    state_t state, state_nxt;

    logic [WIDTH-1:0] op_a, op_b, work_hi, work_lo;
    logic [3:0]       op_ctl;
    logic [CW-1:0]    cnt;
    logic             last;
    logic             accept;

    assign accept = in_valid & in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (accept) begin
                if (MUL_EN && control == 4'b1000)      state_nxt = S_MUL;
                else if (DIV_EN && control == 4'b1001) state_nxt = S_DIV;
                else                                   state_nxt = S_EXEC1;
            end
            S_EXEC1:      state_nxt = S_DONE;
            S_MUL, S_DIV: if (last) state_nxt = S_DONE;
            S_DONE:       if (out_ready) state_nxt = S_IDLE;
            default:      state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == S_IDLE);
        out_valid = (state == S_DONE);
    end

    // One shift-add multiply step: work_hi:work_lo holds partial product : remaining multiplier bits
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH-1:0] mul_hi, mul_lo;
    always_comb begin
        mul_sum = {1'b0, work_hi} + (work_lo[0] ? {1'b0, op_a} : '0);
        mul_hi  = mul_sum[WIDTH:1];
        mul_lo  = {mul_sum[0], work_lo[WIDTH-1:1]};
    end

    // One restoring divide step: work_hi is the partial remainder, work_lo shifts dividend out / quotient in
    logic [WIDTH:0]   div_sh;
    logic             div_ge;
    logic [WIDTH-1:0] div_diff, div_hi, div_lo;
    always_comb begin
        div_sh   = {work_hi, work_lo[WIDTH-1]};
        div_ge   = div_sh >= {1'b0, op_b};
        div_diff = div_sh[WIDTH-1:0] - op_b;
        div_hi   = div_ge ? div_diff : div_sh[WIDTH-1:0];
        div_lo   = {work_lo[WIDTH-2:0], div_ge};
    end

    logic [WIDTH-1:0] alu_res;
    logic             alu_legal;
    always_comb begin
        alu_res   = '0;
        alu_legal = 1'b1;
        case (op_ctl)
            4'b0010: alu_res = op_a + op_b;
            4'b0110: alu_res = op_a - op_b;
            4'b0000: alu_res = op_a & op_b;
            4'b0001: alu_res = op_a | op_b;
            4'b0111: alu_res = {{(WIDTH-1){1'b0}}, op_a < op_b};
            4'b0011: alu_res = op_a ^ op_b;
            4'b0100: alu_res = ~(op_a | op_b);
            default: alu_legal = 1'b0;
        endcase
    end

    logic [WIDTH-1:0] fin_lo, fin_hi;
    logic             fin_dbz, fin_ill;
    always_comb begin
        fin_lo  = work_lo;
        fin_hi  = work_hi;
        fin_dbz = 1'b0;
        fin_ill = 1'b0;
        case (state)
            S_EXEC1: begin
                fin_lo  = alu_res;
                fin_hi  = '0;
                fin_ill = !alu_legal;
            end
            S_DIV: if (op_b == '0) begin
                fin_lo  = '1;
                fin_hi  = op_a;
                fin_dbz = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_a        <= '0;
            op_b        <= '0;
            op_ctl      <= '0;
            work_hi     <= '0;
            work_lo     <= '0;
            cnt         <= '0;
            last        <= 1'b0;
            result      <= '0;
            result_hi   <= '0;
            zero        <= 1'b0;
            div_by_zero <= 1'b0;
            illegal_op  <= 1'b0;
        end else begin
            if (accept) begin
                op_a    <= a;
                op_b    <= b;
                op_ctl  <= control;
                work_hi <= '0;
                work_lo <= (control == 4'b1000) ? b : a;
                cnt     <= '0;
                last    <= 1'b0;
            end else if ((state == S_MUL || state == S_DIV) && !last) begin
                work_hi <= (state == S_MUL) ? mul_hi : div_hi;
                work_lo <= (state == S_MUL) ? mul_lo : div_lo;
                last    <= (cnt == CW'(WIDTH-1));
                cnt     <= (cnt == CW'(WIDTH-1)) ? '0 : cnt + 1'b1;
            end
            if (state != S_DONE && state_nxt == S_DONE) begin
                result      <= fin_lo;
                result_hi   <= fin_hi;
                zero        <= (fin_lo == '0);
                div_by_zero <= fin_dbz;
                illegal_op  <= fin_ill;
            end
        end
    end
endmodule

// File: tb/tb_alu_multicycle.sv
// Directed bench for alu_multicycle: latency, results, flags, backpressure and async reset.
module tb_alu_multicycle;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] a = '0, b = '0;
    logic [3:0]  control = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] result, result_hi;
    logic        zero, div_by_zero, illegal_op;

    int n_cmp = 0;
    int n_err = 0;

    alu_multicycle #(.WIDTH(32), .MUL_EN(1'b1), .DIV_EN(1'b1)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .control(control),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .result_hi(result_hi), .zero(zero),
        .div_by_zero(div_by_zero), .illegal_op(illegal_op)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Issue one op, wait for out_valid (bounded), check latency/results; optionally complete handshake.
    task automatic run_op(input string tag, input logic [3:0] ctl, input logic [31:0] va, input logic [31:0] vb,
                          input int exp_lat, input logic [31:0] exp_lo, input logic [31:0] exp_hi,
                          input logic exp_zero, input logic exp_dbz, input logic exp_ill, input bit handshake);
        int  lat;
        bit  rdy_seen;
        @(negedge clk);
        chk({tag, ".in_ready_pre"}, in_ready, 1'b1);
        in_valid = 1'b1; a = va; b = vb; control = ctl; out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0; a = 32'hDEAD_BEEF; b = 32'h1234_5678; control = 4'b0010;
        lat = 0; rdy_seen = 1'b0;
        while (!out_valid && lat < 100) begin
            if (in_ready) rdy_seen = 1'b1;
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, ".latency"}, lat, exp_lat);
        chk({tag, ".in_ready_busy"}, rdy_seen, 1'b0);
        chk({tag, ".result"}, result, exp_lo);
        chk({tag, ".result_hi"}, result_hi, exp_hi);
        chk({tag, ".flags"}, {zero, div_by_zero, illegal_op}, {exp_zero, exp_dbz, exp_ill});
        if (handshake) begin
            @(negedge clk); out_ready = 1'b1;
            @(posedge clk); #1;
            chk({tag, ".hs_valid_ready"}, {out_valid, in_ready}, 2'b01);
            chk({tag, ".retained"}, result, exp_lo);
            out_ready = 1'b0;
        end
    endtask

    initial begin
        logic [31:0] hold_lo;
        bit          moved;
        #12;
        chk("reset.handshake", {in_ready, out_valid}, 2'b10);
        chk("reset.outputs", {result, result_hi, zero, div_by_zero, illegal_op}, '0);
        @(negedge clk); rst_n = 1'b1;

        run_op("add_wrap", 4'b0010, 32'hFFFF_FFFF, 32'd1, 1, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b1);
        run_op("slt_uns", 4'b0111, 32'd3, 32'h8000_0000, 1, 32'd1, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        run_op("sub_neg", 4'b0110, 32'd5, 32'd7, 1, 32'hFFFF_FFFE, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        run_op("and", 4'b0000, 32'h0000_F0F0, 32'h0000_FF00, 1, 32'h0000_F000, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        run_op("xor", 4'b0011, 32'hAAAA_5555, 32'hFFFF_0000, 1, 32'h5555_5555, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        run_op("nor", 4'b0100, 32'd0, 32'd0, 1, 32'hFFFF_FFFF, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        run_op("multu", 4'b1000, 32'hFFFF_FFFF, 32'd2, 33, 32'hFFFF_FFFE, 32'd1, 1'b0, 1'b0, 1'b0, 1'b1);
        run_op("multu_big", 4'b1000, 32'h0001_0001, 32'hFFFF_0000, 33, 32'hFFFF_0000, 32'h0000_FFFF, 1'b0, 1'b0, 1'b0, 1'b1);
        run_op("divu", 4'b1001, 32'd100, 32'd7, 33, 32'd14, 32'd2, 1'b0, 1'b0, 1'b0, 1'b1);

        // Backpressure: hold out_ready low, poke in_valid, outputs must not move
        run_op("add_bp", 4'b0010, 32'd20, 32'd22, 1, 32'd42, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        hold_lo = result; moved = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); in_valid = (i % 2 == 0); a = 32'd1; b = 32'd1; control = 4'b0010;
            if (in_ready || !out_valid || result !== hold_lo) moved = 1'b1;
        end
        @(negedge clk); in_valid = 1'b0;
        chk("bp.stable", moved, 1'b0);
        chk("bp.result", result, 32'd42);
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp.release", {out_valid, in_ready}, 2'b01);
        out_ready = 1'b0;

        run_op("divu_zero", 4'b1001, 32'd9, 32'd0, 33, 32'hFFFF_FFFF, 32'd9, 1'b0, 1'b1, 1'b0, 1'b1);

        // Async reset in the middle of a multiply
        @(negedge clk);
        in_valid = 1'b1; a = 32'hFFFF_FFFF; b = 32'd2; control = 4'b1000;
        @(posedge clk); #1; in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid.handshake", {out_valid, in_ready}, 2'b01);
        chk("rst_mid.outputs", {result, result_hi, zero, div_by_zero, illegal_op}, '0);
        @(negedge clk); rst_n = 1'b1;

        run_op("or_after_rst", 4'b0001, 32'd6, 32'd3, 1, 32'd7, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        run_op("illegal", 4'b1111, 32'd6, 32'd3, 1, 32'd0, 32'd0, 1'b1, 1'b0, 1'b1, 1'b1);
        run_op("add_after_ill", 4'b0010, 32'd1, 32'd2, 1, 32'd3, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end
endmodule
